// File: rtl/eth_test_pkg.sv
// Shared constants and types for the test Ethernet frame generator/checker.
// Address/size widths, checker FSM encoding, error-bit indices, default addrs.
package eth_test_pkg;

  localparam int ETH_ADDR_WIDTH = 48;
  localparam int ETH_SIZE_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR1 = 2'd1,
    ST_PAY  = 2'd2,
    ST_DONE = 2'd3
  } rx_state_e;

  // err_flags = {runt, keep, len, pat, addr}
  localparam int ERR_ADDR = 0;
  localparam int ERR_PAT  = 1;
  localparam int ERR_LEN  = 2;
  localparam int ERR_KEEP = 3;
  localparam int ERR_RUNT = 4;
  localparam int ERR_W    = 5;

  localparam logic [ETH_ADDR_WIDTH-1:0] DEF_SRC_ADDR = 48'hA0A0_A0A0_A0A0;
  localparam logic [ETH_ADDR_WIDTH-1:0] DEF_DST_ADDR = 48'hA1A1_A1A1_A1A1;

  function automatic logic [7:0] byte_at(logic [63:0] d, int n);
    return d[8*n +: 8];
  endfunction

endpackage

// File: rtl/axis_keep_chk.sv
// Combinational tkeep analysis: popcount and contiguous-from-LSB check.
// Ports: keep_i (KEEP_W), pop_o (set-bit count), contig_o (nonzero, LSB-packed).
module axis_keep_chk #(
  parameter int KEEP_W = 8,
  parameter int POP_W  = $clog2(KEEP_W + 1)
) (
  input  logic [KEEP_W-1:0] keep_i,
  output logic [POP_W-1:0]  pop_o,
  output logic              contig_o
);

  logic [KEEP_W-1:0] kp1;

  always_comb begin
    pop_o = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      pop_o = pop_o + POP_W'(keep_i[i]);
    end
  end

  // A run of ones from bit 0 has no overlap with itself plus one.
  assign kp1      = keep_i + KEEP_W'(1);
  assign contig_o = (keep_i != '0) && ((keep_i & kp1) == '0);

endmodule

// File: rtl/test_axis_rx_chk.sv
// Receive-side checker for 64-bit AXI-Stream test frames: header/pattern/len.
// Ports: rx_axis_* sink (never backpressures), exp_* addrs, chk_clr, status.
module test_axis_rx_chk
  import eth_test_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int CHK_LEN         = 1,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXIS_DATA_WIDTH-1:0]   rx_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] rx_axis_tkeep,
  input  logic                         rx_axis_tvalid,
  input  logic                         rx_axis_tlast,
  output logic                         rx_axis_tready,
  input  logic [ETH_ADDR_WIDTH-1:0]    exp_dst_addr,
  input  logic [ETH_ADDR_WIDTH-1:0]    exp_src_addr,
  input  logic                         chk_clr,
  output logic                         frame_done,
  output logic                         frame_ok,
  output logic [ERR_W-1:0]             err_flags,
  output logic [ETH_SIZE_WIDTH-1:0]    rx_len,
  output logic [CNT_WIDTH-1:0]         frame_cnt,
  output logic [CNT_WIDTH-1:0]         err_cnt,
  output logic                         err_sticky
);

  if (AXIS_DATA_WIDTH != 64) begin : g_bad_width
    $error("test_axis_rx_chk supports only AXIS_DATA_WIDTH = 64");
  end

  localparam int SW = ETH_SIZE_WIDTH;

  rx_state_e state_q, state_d;

  logic             tready_q;
  logic [ERR_W-1:0] flags_q, flags_d;
  logic [ERR_W-1:0] fin_flags;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ok_q, ok_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    len_q, len_d;
  logic [SW-1:0]    rx_len_q, rx_len_d;
  logic [7:0]       val_q, val_d;
  logic [31:0]      src_hi_q, src_hi_d;

  logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] ecnt_q, ecnt_d;
  logic                 sticky_q, sticky_d;

  logic        accept;
  logic        hdr0;
  logic        last_acc;
  logic        done_st;
  logic [3:0]  keep_pop;
  logic        keep_contig;
  logic [SW:0] cnt_sum;
  logic [7:0]  pay_exp;
  logic        pay_bad;

  axis_keep_chk #(
    .KEEP_W (8),
    .POP_W  (4)
  ) u_keep (
    .keep_i   (rx_axis_tkeep),
    .pop_o    (keep_pop),
    .contig_o (keep_contig)
  );

  assign accept   = rx_axis_tvalid & tready_q;
  assign last_acc = accept & rx_axis_tlast;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = rx_axis_tlast ? ST_DONE : ST_HDR1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR1: begin
        if (accept) begin
          state_d = rx_axis_tlast ? ST_DONE : ST_PAY;
        end
      end
      ST_PAY: begin
        if (last_acc) begin
          state_d = ST_DONE;
        end
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    done_st = (state_q == ST_DONE);
    hdr0    = accept &
              ((state_q == ST_IDLE) | (state_q == ST_DONE));
  end

  // ---------------- frame datapath ----------------
  always_comb begin
    pay_exp = val_q + 8'd1;
    pay_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rx_axis_tkeep[i] &&
          byte_at(rx_axis_tdata, i) != pay_exp) begin
        pay_bad = 1'b1;
      end
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + {{(SW - 3){1'b0}}, keep_pop};

  always_comb begin
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    val_d    = val_q;
    src_hi_d = src_hi_q;
    if (hdr0) begin
      // New frame: errors from the previous frame do not carry over.
      flags_d            = '0;
      flags_d[ERR_ADDR]  = (rx_axis_tdata[47:0] != exp_dst_addr) |
                           (rx_axis_tdata[63:48] != exp_src_addr[15:0]);
      flags_d[ERR_KEEP]  = (rx_axis_tkeep != 8'hFF);
      flags_d[ERR_RUNT]  = rx_axis_tlast;
      cnt_d              = '0;
      len_d              = '0;
      val_d              = '0;
      src_hi_d           = exp_src_addr[47:16];
    end else if (accept && state_q == ST_HDR1) begin
      if (rx_axis_tdata[31:0] != src_hi_q) begin
        flags_d[ERR_ADDR] = 1'b1;
      end
      if (rx_axis_tkeep != 8'hFF) begin
        flags_d[ERR_KEEP] = 1'b1;
      end
      if (rx_axis_tdata[63:56] != rx_axis_tdata[55:48]) begin
        flags_d[ERR_PAT] = 1'b1;
      end
      len_d = rx_axis_tdata[47:32];
      val_d = rx_axis_tdata[55:48];
      cnt_d = SW'(2);
    end else if (accept && state_q == ST_PAY) begin
      if (pay_bad) begin
        flags_d[ERR_PAT] = 1'b1;
      end
      if (rx_axis_tlast ? !keep_contig
                        : (rx_axis_tkeep != 8'hFF)) begin
        flags_d[ERR_KEEP] = 1'b1;
      end
      val_d = pay_exp;
      cnt_d = cnt_sum[SW] ? {SW{1'b1}} : cnt_sum[SW-1:0];
    end
  end

  // Final status is captured with the tlast beat so it is
  // presented alongside frame_done in the following cycle.
  always_comb begin
    fin_flags = flags_d;
    if (CHK_LEN != 0 && cnt_d != len_d) begin
      fin_flags[ERR_LEN] = 1'b1;
    end
    err_d    = err_q;
    ok_d     = ok_q;
    rx_len_d = rx_len_q;
    if (last_acc) begin
      err_d    = fin_flags;
      ok_d     = ~|fin_flags;
      rx_len_d = len_d;
    end
  end

  // ---------------- counters ----------------
  always_comb begin
    fcnt_d   = fcnt_q;
    ecnt_d   = ecnt_q;
    sticky_d = sticky_q;
    if (chk_clr) begin
      fcnt_d   = '0;
      ecnt_d   = '0;
      sticky_d = 1'b0;
    end else if (done_st) begin
      fcnt_d = fcnt_q + CNT_WIDTH'(1);
      if (!ok_q) begin
        ecnt_d   = ecnt_q + CNT_WIDTH'(1);
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tready_q <= 1'b0;
      flags_q  <= '0;
      err_q    <= '0;
      ok_q     <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
      rx_len_q <= '0;
      val_q    <= '0;
      src_hi_q <= '0;
      fcnt_q   <= '0;
      ecnt_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      flags_q  <= flags_d;
      err_q    <= err_d;
      ok_q     <= ok_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      rx_len_q <= rx_len_d;
      val_q    <= val_d;
      src_hi_q <= src_hi_d;
      fcnt_q   <= fcnt_d;
      ecnt_q   <= ecnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign rx_axis_tready = tready_q;
  assign frame_done     = done_st;
  assign frame_ok       = ok_q;
  assign err_flags      = err_q;
  assign rx_len         = rx_len_q;
  assign frame_cnt      = fcnt_q;
  assign err_cnt        = ecnt_q;
  assign err_sticky     = sticky_q;

endmodule

// File: tb/tb_test_axis_rx_chk.sv
// Bench for test_axis_rx_chk: table vectors, corner sequences, random frames.
// Two instances share stimulus: one with CHK_LEN=1 (_a), one with CHK_LEN=0 (_b).
module tb_test_axis_rx_chk;
  import eth_test_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic [47:0] exp_dst;
  logic [47:0] exp_src;
  logic        chk_clr;

  logic        tready_a, done_a, ok_a, sticky_a;
  logic [4:0]  flags_a;
  logic [15:0] len_a;
  logic [31:0] fcnt_a, ecnt_a;
  logic        tready_b, done_b, ok_b, sticky_b;
  logic [4:0]  flags_b;
  logic [15:0] len_b;
  logic [31:0] fcnt_b, ecnt_b;

  always #5 clk = ~clk;

  test_axis_rx_chk #(.AXIS_DATA_WIDTH(64), .CHK_LEN(1), .CNT_WIDTH(32)) u_a (
    .clk(clk), .rst(rst),
    .rx_axis_tdata(tdata), .rx_axis_tkeep(tkeep),
    .rx_axis_tvalid(tvalid), .rx_axis_tlast(tlast),
    .rx_axis_tready(tready_a),
    .exp_dst_addr(exp_dst), .exp_src_addr(exp_src),
    .chk_clr(chk_clr),
    .frame_done(done_a), .frame_ok(ok_a), .err_flags(flags_a),
    .rx_len(len_a), .frame_cnt(fcnt_a), .err_cnt(ecnt_a),
    .err_sticky(sticky_a)
  );

  test_axis_rx_chk #(.AXIS_DATA_WIDTH(64), .CHK_LEN(0), .CNT_WIDTH(32)) u_b (
    .clk(clk), .rst(rst),
    .rx_axis_tdata(tdata), .rx_axis_tkeep(tkeep),
    .rx_axis_tvalid(tvalid), .rx_axis_tlast(tlast),
    .rx_axis_tready(tready_b),
    .exp_dst_addr(exp_dst), .exp_src_addr(exp_src),
    .chk_clr(chk_clr),
    .frame_done(done_b), .frame_ok(ok_b), .err_flags(flags_b),
    .rx_len(len_b), .frame_cnt(fcnt_b), .err_cnt(ecnt_b),
    .err_sticky(sticky_b)
  );

  int tests  = 0;
  int failed = 0;

  logic [63:0] fd[16];
  logic [7:0]  fk[16];
  int          fn;

  int m_fcnt, m_ecnt_a, m_ecnt_b;
  bit m_stk_a, m_stk_b;

  typedef struct {
    string       name;
    logic [47:0] dst;
    int          flip;
    logic [7:0]  lkeep;
    bit          runt;
    logic [15:0] len;
    logic [4:0]  fa;
    logic [4:0]  fb;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int popc(logic [7:0] k);
    int p = 0;
    for (int i = 0; i < 8; i++) p += int'(k[i]);
    return p;
  endfunction

  function automatic bit contig(logic [7:0] k);
    int p = popc(k);
    return (p > 0) && (k == 8'((16'd1 << p) - 16'd1));
  endfunction

  // Frame-level reference: walks the beat list and applies the header,
  // pattern, keep and length rules directly.
  function automatic logic [4:0] model_flags(bit chk_len,
      logic [47:0] ed, logic [47:0] es);
    logic [4:0]  f = '0;
    int          cnt = 0;
    logic [15:0] ln = '0;
    logic [7:0]  v;
    if (fn == 1) f[ERR_RUNT] = 1'b1;
    if (fd[0][47:0] != ed || fd[0][63:48] != es[15:0]) f[ERR_ADDR] = 1'b1;
    if (fk[0] != 8'hFF) f[ERR_KEEP] = 1'b1;
    if (fn > 1) begin
      if (fd[1][31:0] != es[47:16]) f[ERR_ADDR] = 1'b1;
      if (fk[1] != 8'hFF) f[ERR_KEEP] = 1'b1;
      if (fd[1][63:56] != fd[1][55:48]) f[ERR_PAT] = 1'b1;
      ln  = fd[1][47:32];
      cnt = 2;
    end
    for (int i = 2; i < fn; i++) begin
      v = fd[1][55:48] + 8'(i - 1);
      for (int j = 0; j < 8; j++)
        if (fk[i][j] && fd[i][8*j +: 8] != v) f[ERR_PAT] = 1'b1;
      if (i < fn - 1 ? fk[i] != 8'hFF : !contig(fk[i])) f[ERR_KEEP] = 1'b1;
      cnt += popc(fk[i]);
    end
    if (cnt > 65535) cnt = 65535;
    if (chk_len && cnt != int'(ln)) f[ERR_LEN] = 1'b1;
    return f;
  endfunction

  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
      input logic [15:0] len, input logic [7:0] seed, input int npay,
      input bit runt, input logic [7:0] lkeep);
    logic [7:0] v;
    fd[0] = {src[15:0], dst};
    fk[0] = 8'hFF;
    if (runt) begin
      fn = 1;
      return;
    end
    fd[1] = {seed, seed, len, src[47:16]};
    fk[1] = 8'hFF;
    fn = 2 + npay;
    for (int i = 1; i <= npay; i++) begin
      v = seed + 8'(i);
      fd[i+1] = {8{v}};
      fk[i+1] = (i == npay) ? lkeep : 8'hFF;
    end
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k,
                            input bit l);
    tvalid = 1'b1;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < fn; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      drive_beat(fd[i], fk[i], i == fn - 1);
      if (i < fn - 1) chk("no_early_done", {31'b0, done_b}, 0);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  fa, fb;
    logic [15:0] rl, clen, len;
    logic [7:0]  lk, seed;
    int          npay, k, bi;
    bit          runt;

    rst     = 1'b1;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    tdata   = '0;
    tkeep   = '0;
    chk_clr = 1'b0;
    exp_dst = DEF_DST_ADDR;
    exp_src = DEF_SRC_ADDR;

    tbl[0] = '{"nominal", DEF_DST_ADDR, -1, 8'h3F, 1'b0, 16'd14, 5'b00100, 5'b00000};
    tbl[1] = '{"corrupt", DEF_DST_ADDR,  3, 8'h3F, 1'b0, 16'd14, 5'b00110, 5'b00010};
    tbl[2] = '{"dst_bad", 48'hA1A1_A1A1_A1A2, -1, 8'h3F, 1'b0, 16'd14, 5'b00101, 5'b00001};
    tbl[3] = '{"runt",    DEF_DST_ADDR, -1, 8'h3F, 1'b1, 16'd14, 5'b10000, 5'b10000};
    tbl[4] = '{"keep5f",  DEF_DST_ADDR, -1, 8'h5F, 1'b0, 16'd14, 5'b01100, 5'b01000};
    tbl[5] = '{"good16",  DEF_DST_ADDR, -1, 8'h3F, 1'b0, 16'd16, 5'b00000, 5'b00000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", {31'b0, tready_b}, 0);
    chk("rst_done", {31'b0, done_a}, 0);
    chk("rst_flags", {27'b0, flags_a}, 0);
    chk("rst_fcnt", fcnt_a, 0);
    chk("rst_sticky", {31'b0, sticky_b}, 0);
    rst = 1'b0;
    idle_cycle();
    chk("tready_up", {30'b0, tready_a, tready_b}, 3);

    // ---- table-driven vectors ----
    m_fcnt = 0; m_ecnt_a = 0; m_ecnt_b = 0;
    foreach (tbl[i]) begin
      exp_dst = tbl[i].dst;
      exp_src = DEF_SRC_ADDR;
      build_frame(DEF_DST_ADDR, DEF_SRC_ADDR, tbl[i].len, 8'h05, 2,
                  tbl[i].runt, tbl[i].lkeep);
      if (tbl[i].flip >= 0) fd[2][8*tbl[i].flip +: 8] = 8'h16;
      send_frame(0);
      chk({tbl[i].name, "_done"}, {31'b0, done_b}, 1);
      chk({tbl[i].name, "_flags_a"}, {27'b0, flags_a}, {27'b0, tbl[i].fa});
      chk({tbl[i].name, "_flags_b"}, {27'b0, flags_b}, {27'b0, tbl[i].fb});
      chk({tbl[i].name, "_ok_b"}, {31'b0, ok_b}, {31'b0, tbl[i].fb == 0});
      chk({tbl[i].name, "_rxlen"}, {16'b0, len_a},
          tbl[i].runt ? 32'd0 : {16'b0, tbl[i].len});
      chk({tbl[i].name, "_fcnt_pre"}, fcnt_b, m_fcnt);
      idle_cycle();
      m_fcnt++;
      if (tbl[i].fa != 0) m_ecnt_a++;
      if (tbl[i].fb != 0) m_ecnt_b++;
      chk({tbl[i].name, "_done_1cyc"}, {31'b0, done_b}, 0);
      chk({tbl[i].name, "_fcnt"}, fcnt_b, m_fcnt);
      chk({tbl[i].name, "_ecnt_a"}, ecnt_a, m_ecnt_a);
      chk({tbl[i].name, "_ecnt_b"}, ecnt_b, m_ecnt_b);
    end
    chk("tbl_sticky", {30'b0, sticky_a, sticky_b}, 3);

    // ---- chk_clr coincident with frame_done ----
    exp_dst = DEF_DST_ADDR;
    build_frame(DEF_DST_ADDR, DEF_SRC_ADDR, 16'd16, 8'h05, 2, 1'b0, 8'h3F);
    send_frame(0);
    chk_clr = 1'b1;
    chk("clr_done", {31'b0, done_b}, 1);
    chk("clr_ok", {30'b0, ok_a, ok_b}, 3);
    idle_cycle();
    chk_clr = 1'b0;
    chk("clr_fcnt", fcnt_b, 0);
    chk("clr_ecnt", ecnt_a, 0);
    chk("clr_sticky", {30'b0, sticky_a, sticky_b}, 0);

    // ---- back-to-back frames, second header accepted in DONE ----
    send_frame(0);
    chk("b2b_done1", {31'b0, done_b}, 1);
    send_frame(0);
    chk("b2b_done2", {31'b0, done_b}, 1);
    chk("b2b_fcnt_mid", fcnt_b, 1);
    chk("b2b_ok2", {31'b0, ok_a}, 1);
    idle_cycle();
    chk("b2b_fcnt", fcnt_b, 2);

    // ---- reset mid-payload ----
    build_frame(DEF_DST_ADDR, DEF_SRC_ADDR, 16'd16, 8'h05, 2, 1'b0, 8'h3F);
    for (int i = 0; i < 3; i++) drive_beat(fd[i], fk[i], 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_tready", {31'b0, tready_b}, 0);
    chk("midrst_fcnt", fcnt_b, 0);
    idle_cycle();
    rst = 1'b0;
    idle_cycle();
    chk("midrst_fcnt_hold", fcnt_a, 0);
    send_frame(0);
    chk("post_rst_ok", {30'b0, ok_a, ok_b}, 3);
    chk("post_rst_flags", {27'b0, flags_a}, 0);
    idle_cycle();
    chk("post_rst_fcnt", fcnt_b, 1);
    m_fcnt = 1; m_ecnt_a = 0; m_ecnt_b = 0;
    m_stk_a = 0; m_stk_b = 0;

    // ---- randomized frames against the reference model ----
    for (int n = 0; n < 150; n++) begin
      runt = ($urandom_range(0, 9) == 0);
      npay = $urandom_range(0, 4);
      seed = 8'($urandom);
      k    = $urandom_range(1, 8);
      lk   = 8'((16'd1 << k) - 16'd1);
      if ($urandom_range(0, 5) == 0) lk = 8'($urandom);
      clen = (npay == 0) ? 16'd2 : 16'(2 + 8 * (npay - 1) + k);
      len  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 50)) : clen;
      exp_dst = DEF_DST_ADDR;
      exp_src = DEF_SRC_ADDR;
      if ($urandom_range(0, 7) == 0)
        exp_dst = DEF_DST_ADDR ^ (48'd1 << $urandom_range(0, 47));
      if ($urandom_range(0, 7) == 0)
        exp_src = DEF_SRC_ADDR ^ (48'd1 << $urandom_range(0, 47));
      build_frame(DEF_DST_ADDR, DEF_SRC_ADDR, len, seed, npay, runt, lk);
      if ($urandom_range(0, 5) == 0) begin
        bi = $urandom_range(0, fn - 1);
        fd[bi][8*$urandom_range(0, 7) +: 8] ^= 8'($urandom_range(1, 255));
      end
      if (fn > 1 && $urandom_range(0, 9) == 0)
        fk[$urandom_range(0, fn - 2)] = 8'($urandom);
      fa = model_flags(1'b1, exp_dst, exp_src);
      fb = model_flags(1'b0, exp_dst, exp_src);
      rl = (fn > 1) ? fd[1][47:32] : 16'd0;
      send_frame(2);
      chk("rand_done", {31'b0, done_a}, 1);
      chk("rand_flags_a", {27'b0, flags_a}, {27'b0, fa});
      chk("rand_flags_b", {27'b0, flags_b}, {27'b0, fb});
      chk("rand_ok_a", {31'b0, ok_a}, {31'b0, fa == 0});
      chk("rand_rxlen", {16'b0, len_b}, {16'b0, rl});
      chk("rand_fcnt", fcnt_a, m_fcnt);
      chk("rand_ecnt_a", ecnt_a, m_ecnt_a);
      chk("rand_ecnt_b", ecnt_b, m_ecnt_b);
      m_fcnt++;
      if (fa != 0) begin m_ecnt_a++; m_stk_a = 1; end
      if (fb != 0) begin m_ecnt_b++; m_stk_b = 1; end
    end
    idle_cycle();
    chk("final_fcnt", fcnt_b, m_fcnt);
    chk("final_ecnt_a", ecnt_a, m_ecnt_a);
    chk("final_ecnt_b", ecnt_b, m_ecnt_b);
    chk("final_sticky", {30'b0, sticky_a, sticky_b}, {30'b0, m_stk_a, m_stk_b});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/test_axis_rx_chk.md
Name: test_axis_rx_chk

Overview:
Downstream consumer of the test AXI-Stream frame generator. It accepts 64-bit Ethernet-style test frames, parses the destination, source and length header, and checks the payload byte pattern. It reports per-frame status and keeps running frame and error counters. It sits on the loopback/receive side of eth_ctrl, so generator-to-MAC-to-checker paths can be self-checked in hardware.

Parameters:
AXIS_DATA_WIDTH, 64, stream width in bits; only 64 is supported, and elaboration fails for any other value.
CHK_LEN, 1, 1 = compare the length field against the received payload byte count; 0 = ignore the length field.
CNT_WIDTH, 32, width of frame_cnt and err_cnt.

Ports:
clk  in  1  system clock
rst  in  1  reset, active-high, asynchronous
rx_axis_tdata  in  64  stream data, byte n = tdata[8n+7:8n]
rx_axis_tkeep  in  8  byte qualifiers
rx_axis_tvalid  in  1  beat valid
rx_axis_tlast  in  1  last beat of frame
rx_axis_tready  out  1  checker ready
exp_dst_addr  in  48  expected destination address, sampled at frame start
exp_src_addr  in  48  expected source address, sampled at frame start
chk_clr  in  1  synchronous clear of the counters and sticky error
frame_done  out  1  one-cycle pulse at the end of each frame
frame_ok  out  1  valid with frame_done; 1 = no errors in this frame
err_flags  out  5  {runt, keep, len, pat, addr}, valid with frame_done
rx_len  out  16  length field of the last frame
frame_cnt  out  CNT_WIDTH  frames completed
err_cnt  out  CNT_WIDTH  frames with frame_ok = 0
err_sticky  out  1  set on any bad frame; cleared only by chk_clr or rst

Behaviour:
- Reset values: all outputs are 0, and the FSM is in IDLE.
- rx_axis_tready is a register: 0 in reset, then 1 from the first clk edge after rst deasserts. The checker never backpressures.
- A beat is accepted when tvalid & tready. Nothing advances without an accepted beat.
- FSM states:
  - IDLE: an accepted beat is header beat 0. Sample exp_* here. Check bytes 0-5 == exp_dst and bytes 6-7 == exp_src[15:0]. tkeep must be 8'hFF. Go to HDR1. If tlast is set, flag runt and go to DONE.
  - HDR1: check bytes 0-3 == exp_src[47:16] and tkeep == 8'hFF. Latch the length field = tdata[47:32] into len_q. Seed = byte 6; pat error if byte 7 != byte 6. Payload byte count starts at 2. On tlast, go to DONE; otherwise go to PAY.
  - PAY: expected value = previous beat value + 1 (mod 256). Every byte whose tkeep bit is 1 must equal the expected value.
    - Non-last beat: tkeep must be 8'hFF.
    - Last beat: tkeep must be contiguous from bit 0 and nonzero, otherwise keep error.
    - Byte count accumulates popcount(tkeep) in 16 bits, saturating at 16'hFFFF.
    - On tlast, go to DONE.
  - DONE: exactly one cycle; tready stays 1. A beat accepted in DONE is treated as the IDLE (header beat 0) case. The frame is not dropped.
- len error: CHK_LEN = 1 and byte count != len_q. The check is evaluated in DONE.
- DONE outputs:
  - frame_done = 1 for one cycle; frame_ok = ~|err_flags.
  - rx_len = len_q; the err_flags register is loaded.
  - frame_cnt increments; err_cnt increments if the frame is bad. Both wrap at 2^CNT_WIDTH.
- Error flags are sticky within a frame and are cleared on entry to HDR0 processing (IDLE/DONE acceptance).
- chk_clr in the same cycle as frame_done: the clear wins. Counters go to 0 and err_sticky to 0, and the current frame is not counted. frame_done and frame_ok still pulse.
- rst mid-frame: the FSM returns to IDLE and the partial frame is discarded uncounted.
- tvalid low mid-frame: the state holds indefinitely; there is no timeout.
- Latency: frame_done is asserted in the cycle after the tlast beat is accepted.

Decomposition:
- Shared package eth_test_pkg holds:
  - the ETH_ADDR_WIDTH = 48 and ETH_SIZE_WIDTH = 16 constants;
  - the FSM state encoding (IDLE, HDR1, PAY, DONE);
  - the error-bit index constants;
  - the default test addresses 48'hA0A0_A0A0_A0A0 (src) and 48'hA1A1_A1A1_A1A1 (dst).
- One sub-module, axis_keep_chk: combinational popcount of tkeep plus the contiguous-from-LSB check. It is reused by future 32-bit variants.

Test Plan:
- Nominal frame, no errors:
  - Header beat 0 with dst A1..A1 and src[15:0] A0A0.
  - Header beat 1 with length 16'd14 and seed 8'h05.
  - 1 full payload beat of 8'h06, then a last beat of 8'h07 with tkeep 8'h3F.
  - Payload bytes 2 + 8 + 6 = 16.
  - Required: CHK_LEN = 0 gives frame_ok = 1 and frame_cnt = 1; CHK_LEN = 1 gives len error, err_flags = 5'b00100.
- Corrupt one payload byte (8'h06 becomes 8'h16) -> pat set, err_cnt = 1, err_sticky = 1.
- Destination mismatch (exp_dst = A1..A2) -> addr set, frame_ok = 0.
- tlast on beat 0 -> runt set, frame_done 1 cycle later, frame_cnt +1.
- Last beat tkeep 8'h5F -> keep error.
- Back-to-back frames with the second header accepted in DONE: both counted, frame_cnt = 2.
- rst asserted mid-PAY: tready = 0, counters stay at 0, and a following clean frame passes.
- chk_clr coincident with frame_done -> frame_cnt = 0 and err_cnt = 0 afterwards.
